// File: rtl/router_port_arbiter.sv
// Output-port scheduler for the 16x16 serial router.
// Each output port runs an IDLE -> OWNED -> GAP FSM: a round-robin pick among
// the inputs addressing it, ownership held until the owner's done pulse or the
// hold watchdog, then a one-cycle turnaround gap before the next arbitration.
module router_port_arbiter #(
  parameter int unsigned NPORTS     = 16,
  parameter int unsigned AW         = 4,
  parameter int unsigned HOLD_LIMIT = 1023
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NPORTS-1:0]    req,
  input  logic [NPORTS*AW-1:0] req_da,
  input  logic [NPORTS-1:0]    done,
  output logic [NPORTS-1:0]    grant,
  output logic [NPORTS*AW-1:0] out_owner,
  output logic [NPORTS-1:0]    out_active,
  output logic [NPORTS-1:0]    timeout_err
);

  // Counter saturates into the release, so it never needs to hold HOLD_LIMIT itself.
  localparam int unsigned CW = (HOLD_LIMIT > 0) ? $clog2(HOLD_LIMIT + 1) : 1;
  localparam logic [CW-1:0] HoldLast = CW'(HOLD_LIMIT - 1);

  typedef enum logic [1:0] {StIdle, StOwned, StGap} state_e;

  state_e              state_q [NPORTS];
  logic [AW-1:0]       rr_q    [NPORTS];
  logic [CW-1:0]       hold_q  [NPORTS];
  logic [NPORTS-1:0]   grant_q;
  logic [NPORTS-1:0]   active_q;
  logic [NPORTS-1:0]   terr_q;
  logic [NPORTS*AW-1:0] owner_q;

  logic [NPORTS-1:0]   win_vld;
  logic [AW-1:0]       win_idx [NPORTS];
  logic [AW-1:0]       win_nxt [NPORTS];

  // Round-robin search per output: first ungranted requester at or above rr, wrapping.
  always_comb begin
    int unsigned idx;
    idx = 0;
    for (int unsigned j = 0; j < NPORTS; j++) begin
      win_vld[j] = 1'b0;
      win_idx[j] = '0;
      for (int unsigned k = 0; k < NPORTS; k++) begin
        idx = (32'(rr_q[j]) + k) % NPORTS;
        if (!win_vld[j] && req[idx] && !grant_q[idx] &&
            req_da[idx*AW +: AW] == AW'(j)) begin
          win_vld[j] = 1'b1;
          win_idx[j] = AW'(idx);
        end
      end
      win_nxt[j] = AW'((32'(win_idx[j]) + 1) % NPORTS);
    end
  end

  // Per-output FSMs with registered grant/owner/active/timeout outputs.
  // An input appears in at most one output's candidate set and a granted input
  // is never a candidate, so the per-bit grant updates never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned j = 0; j < NPORTS; j++) begin
        state_q[j] <= StIdle;
        rr_q[j]    <= '0;
        hold_q[j]  <= '0;
      end
      grant_q  <= '0;
      active_q <= '0;
      owner_q  <= '0;
      terr_q   <= '0;
    end else begin
      terr_q <= '0;
      for (int unsigned j = 0; j < NPORTS; j++) begin
        case (state_q[j])
          StIdle: begin
            if (win_vld[j]) begin
              state_q[j]               <= StOwned;
              active_q[j]              <= 1'b1;
              owner_q[j*AW +: AW]      <= win_idx[j];
              grant_q[win_idx[j]]      <= 1'b1;
              rr_q[j]                  <= win_nxt[j];
              hold_q[j]                <= '0;
            end
          end
          StOwned: begin
            if (done[owner_q[j*AW +: AW]] ||
                (HOLD_LIMIT != 0 && hold_q[j] == HoldLast)) begin
              state_q[j]                      <= StGap;
              active_q[j]                     <= 1'b0;
              owner_q[j*AW +: AW]             <= '0;
              grant_q[owner_q[j*AW +: AW]]    <= 1'b0;
              // done wins over the watchdog when both land on the same edge
              terr_q[j]                       <= !done[owner_q[j*AW +: AW]];
            end else begin
              hold_q[j] <= hold_q[j] + 1'b1;
            end
          end
          StGap:   state_q[j] <= StIdle;
          default: state_q[j] <= StIdle;
        endcase
      end
    end
  end

  assign grant       = grant_q;
  assign out_owner   = owner_q;
  assign out_active  = active_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_router_port_arbiter.sv
// Self-checking bench for router_port_arbiter: directed scenarios plus random
// traffic, every cycle compared against a behavioural ownership model.
module tb_router_port_arbiter;

  localparam int unsigned N  = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned HL = 8;

  logic              clock;
  logic              reset;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_da;
  logic [N-1:0]      done;
  logic [N-1:0]      grant;
  logic [N*AW-1:0]   out_owner;
  logic [N-1:0]      out_active;
  logic [N-1:0]      timeout_err;

  router_port_arbiter #(
    .NPORTS    (N),
    .AW        (AW),
    .HOLD_LIMIT(HL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .req_da     (req_da),
    .done       (done),
    .grant      (grant),
    .out_owner  (out_owner),
    .out_active (out_active),
    .timeout_err(timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: who owns each output (-1 = nobody), whether it is cooling down,
  // the edge number it was taken at, and where the next search starts.
  int         m_own   [N];
  bit         m_gap   [N];
  int         m_start [N];
  int         m_rr    [N];
  bit [N-1:0] m_terr;
  int         cyc = 0;

  function automatic logic [N-1:0] e_grant();
    logic [N-1:0] v = '0;
    for (int j = 0; j < N; j++) if (m_own[j] >= 0) v[m_own[j]] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] e_active();
    logic [N-1:0] v = '0;
    for (int j = 0; j < N; j++) v[j] = (m_own[j] >= 0);
    return v;
  endfunction

  function automatic logic [N*AW-1:0] e_owner();
    logic [N*AW-1:0] v = '0;
    for (int j = 0; j < N; j++) if (m_own[j] >= 0) v[j*AW +: AW] = AW'(m_own[j]);
    return v;
  endfunction

  task automatic m_step();
    logic [N-1:0] held;
    cyc++;
    held   = e_grant();
    m_terr = '0;
    if (reset) begin
      for (int j = 0; j < N; j++) begin
        m_own[j] = -1; m_gap[j] = 0; m_rr[j] = 0;
      end
      return;
    end
    for (int j = 0; j < N; j++) begin
      if (m_gap[j]) begin
        m_gap[j] = 0;
      end else if (m_own[j] >= 0) begin
        if (done[m_own[j]]) begin
          m_own[j] = -1; m_gap[j] = 1;
        end else if (cyc - m_start[j] == int'(HL)) begin
          m_own[j] = -1; m_gap[j] = 1; m_terr[j] = 1'b1;
        end
      end else begin
        for (int off = 0; off < N; off++) begin
          int i = (m_rr[j] + off) % N;
          if (req[i] && !held[i] && int'(req_da[i*AW +: AW]) == j) begin
            m_own[j] = i; m_start[j] = cyc; m_rr[j] = (i + 1) % N;
            break;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    m_step();
    #1;
    check_eq("grant", grant, e_grant());
    check_eq("out_active", out_active, e_active());
    check_eq("out_owner", out_owner, e_owner());
    check_eq("timeout_err", timeout_err, m_terr);
  endtask

  task automatic set_req(input int i, input int d);
    req[i] = 1'b1;
    req_da[i*AW +: AW] = AW'(d);
  endtask

  // Wait (bounded) for output j to be taken, check the owner, run a 6-cycle frame.
  task automatic serve(input int j, input int exp_owner);
    int w = 0;
    while (!out_active[j] && w < 40) begin
      tick();
      w++;
    end
    check_eq("serve_active", out_active[j], 1'b1);
    check_eq("serve_owner", out_owner[j*AW +: AW], exp_owner);
    req[exp_owner] = 1'b0;
    repeat (5) tick();
    done[exp_owner] = 1'b1;
    tick();
    done[exp_owner] = 1'b0;
  endtask

  int         cnt [N];
  logic [N-1:0] gr, prev_gr;

  initial begin
    req = '0; req_da = '0; done = '0; reset = 1'b1;
    for (int j = 0; j < N; j++) begin
      m_own[j] = -1; m_gap[j] = 0; m_rr[j] = 0; m_start[j] = 0; cnt[j] = 0;
    end
    m_terr = '0;
    tick(); tick();
    check_eq("reset_grant", grant, '0);
    check_eq("reset_active", out_active, '0);
    reset = 1'b0;
    tick();

    // Single frame: input 3 -> output 5.
    set_req(3, 5);
    tick();
    check_eq("t1_grant3", grant[3], 1'b1);
    check_eq("t1_owner5", out_owner[5*AW +: AW], 3);
    req[3] = 1'b0;
    repeat (4) tick();
    done[3] = 1'b1;
    tick();
    done[3] = 1'b0;
    check_eq("t1_release", {grant[3], out_active[5]}, 2'b00);
    tick(); tick();

    // Round-robin order on output 0, then re-request of input 1.
    set_req(1, 0); set_req(7, 0); set_req(12, 0);
    serve(0, 1);
    set_req(1, 0);
    serve(0, 7);
    serve(0, 12);
    serve(0, 1);

    // Wrap-around: push rr[0] to 13, then 2 and 14 compete.
    set_req(12, 0);
    serve(0, 12);
    set_req(2, 0); set_req(14, 0);
    serve(0, 14);
    serve(0, 2);
    set_req(0, 0); set_req(3, 0);
    serve(0, 3);
    serve(0, 0);
    tick(); tick();

    // Parallel grants and the two-edge re-grant gap on output 4.
    set_req(0, 4); set_req(1, 9);
    tick();
    check_eq("t4_parallel", grant[1:0], 2'b11);
    req[0] = 1'b0; req[1] = 1'b0;
    set_req(2, 4);
    tick();
    check_eq("t4_held_off", grant[2], 1'b0);
    done[0] = 1'b1; done[1] = 1'b1;
    tick();
    done[0] = 1'b0; done[1] = 1'b0;
    check_eq("t4_gap_edge", grant[2], 1'b0);
    tick();
    check_eq("t4_idle_edge", grant[2], 1'b0);
    tick();
    check_eq("t4_regrant", grant[2], 1'b1);
    req[2] = 1'b0;
    done[2] = 1'b1;
    tick();
    done[2] = 1'b0;
    tick(); tick();

    // Watchdog: input 6 -> output 3 with no done.
    set_req(6, 3);
    tick();
    req[6] = 1'b0;
    repeat (7) tick();
    check_eq("t5_still_owned", grant[6], 1'b1);
    tick();
    check_eq("t5_forced", {grant[6], timeout_err[3]}, 2'b01);
    tick();
    check_eq("t5_one_pulse", timeout_err[3], 1'b0);
    done[6] = 1'b1;
    tick();
    done[6] = 1'b0;
    check_eq("t5_late_done", out_active[3], 1'b0);
    tick(); tick();

    // Reset with four outputs owned; rr must restart from 0.
    for (int i = 0; i < 4; i++) set_req(i, 10 + i);
    tick();
    req = '0;
    check_eq("t6_owned", out_active[13:10], 4'hf);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_eq("t6_clear", {grant, out_active}, '0);
    set_req(0, 10); set_req(5, 10);
    tick();
    check_eq("t6_rr_zero", out_owner[10*AW +: AW], 0);
    req = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Random traffic with contention, spurious/late done pulses and occasional reset.
    prev_gr = '0;
    for (int c = 0; c < 3000; c++) begin
      gr = e_grant();
      reset = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < N; i++) begin
        done[i] = 1'b0;
        if (gr[i] && !prev_gr[i]) begin
          cnt[i] = int'($urandom_range(1, 12));
          if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
        end
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) done[i] = 1'b1;
        end else if ($urandom_range(0, 49) == 0) begin
          done[i] = 1'b1;
        end
        if (!gr[i] && !req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_da[i*AW +: AW] = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3))
                                                          : AW'($urandom_range(0, N - 1));
        end
      end
      prev_gr = gr;
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
